// File: rtl/dot_product_engine_pkg.sv
// Shared definitions for the dot-product compute stage: FSM encoding and
// default widths, also used when integrating with general_controller.
package dot_product_engine_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } dpe_state_e;

  localparam int unsigned DPE_DATA_W = 8;
  localparam int unsigned DPE_LEN    = 16;
  localparam int unsigned DPE_ADDR_W = 4;
  localparam int unsigned DPE_ACC_W  = 20;

  // Smallest accumulator that cannot overflow for a given operand width/length.
  function automatic int unsigned dpe_min_acc_w(input int unsigned data_w,
                                                input int unsigned len);
    return 2 * data_w + $clog2(len);
  endfunction

endpackage

// File: rtl/dot_product_engine_mac.sv
// Registered signed multiply-accumulate: acc <= clear ? 0 : acc + a*b when en.
module mac_unit
  import dot_product_engine_pkg::*;
#(
  parameter int unsigned DATA_W = DPE_DATA_W,
  parameter int unsigned ACC_W  = DPE_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic        [ACC_W-1:0]    prod_ext;
  logic        [ACC_W-1:0]    acc_q, acc_d;

  always_comb begin
    prod     = (2*DATA_W)'($signed(a)) * (2*DATA_W)'($signed(b));
    prod_ext = ACC_W'(prod);
    acc_d    = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/dot_product_engine.sv
// Dot-product engine: streams LEN operand pairs from two 1-cycle-latency
// buffers, signed-MACs them and reports the result with a done pulse.
module dot_product_engine
  import dot_product_engine_pkg::*;
#(
  parameter int unsigned DATA_W = DPE_DATA_W,
  parameter int unsigned LEN    = DPE_LEN,
  parameter int unsigned ADDR_W = DPE_ADDR_W,
  parameter int unsigned ACC_W  = DPE_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inner_start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic              busy,
  output logic [ACC_W-1:0]  result,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LEN - 1);

  dpe_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ACC_W-1:0]  result_q, result_d;
  logic [ACC_W-1:0]  acc;
  logic              valid_q;
  logic              acc_clear;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    result_d  = result_q;
    acc_clear = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (inner_start) begin
          state_d   = S_RUN;
          addr_d    = '0;
          result_d  = '0;
          acc_clear = 1'b1;
        end
      end
      S_RUN: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        state_d  = S_IDLE;
        result_d = acc;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      result_q <= result_d;
      valid_q  <= rd_en;
    end
  end

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clear (acc_clear),
    .en    (valid_q),
    .a     (a_data),
    .b     (b_data),
    .acc   (acc)
  );

  assign rd_en   = (state_q == S_RUN);
  assign rd_addr = addr_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  // The last pair lands in the accumulator on the DONE entry edge, so DONE
  // shows the accumulator directly and the register captures it on exit.
  assign result  = done ? acc : result_q;

endmodule

// File: doc/dot_product_engine.md
Name: dot_product_engine

Overview:
- Compute stage directly downstream of general_controller.
- On each inner_start pulse it streams LEN operand pairs from two synchronous-read operand buffers, multiply-accumulates them as signed values, and holds the result.
- It then returns a one-cycle done pulse, which the controller consumes to go back to WAIT.
- Operand buffers are external, with 1-cycle read latency; this block only drives a shared read address and enable.

Parameters:
- DATA_W, 8, operand width (signed two's complement).
- LEN, 16, number of operand pairs per computation; must be at least 2.
- ADDR_W, 4, buffer address width; 2^ADDR_W must be at least LEN.
- ACC_W, 20, accumulator/result width; must be at least 2*DATA_W + ceil(log2(LEN)).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- inner_start  in  1  start pulse from general_controller; sampled only in IDLE.
- rd_en  out  1  read enable to both operand buffers.
- rd_addr  out  ADDR_W  shared read address to both buffers.
- a_data  in  DATA_W  buffer A read data, valid the cycle after the address is presented.
- b_data  in  DATA_W  buffer B read data, same timing as a_data.
- busy  out  1  high in every state except IDLE.
- result  out  ACC_W  signed dot product; holds its value until the next accepted inner_start.
- done  out  1  one-cycle completion pulse back to general_controller.

Behaviour:
- States: IDLE, RUN, DRAIN, DONE. Reset forces IDLE.
- Reset values: rd_en=0, rd_addr=0, busy=0, done=0, result=0; accumulator=0, data-valid flag=0. Reset mid-operation aborts immediately, with no done pulse.
- IDLE:
  - inner_start=1 gives next state RUN, rd_addr=0, accumulator cleared, result cleared.
  - inner_start=0 stays in IDLE.
- RUN:
  - rd_en=1 and rd_addr is presented; rd_addr increments by 1 each cycle.
  - When rd_addr==LEN-1 is being presented, next state is DRAIN and rd_addr returns to 0. rd_addr never wraps past LEN-1.
- Data-valid flag:
  - Registered copy of rd_en.
  - When set, the accumulator updates to accumulator + sign-extended(a_data*b_data).
  - The product is a full 2*DATA_W signed value; accumulation is at ACC_W with no saturation.
- DRAIN: rd_en=0; the last pair is accumulated this cycle; next state DONE.
- DONE:
  - done=1 for exactly this cycle; result loads the final accumulator value at entry to DONE and is visible while done=1.
  - Next state is IDLE.
- done and busy are Moore outputs decoded from state only.
- Latency: inner_start sampled at edge 0 gives:
  - rd_addr=k during cycle k+1, for k = 0..LEN-1;
  - DRAIN in cycle LEN+1;
  - done=1 in cycle LEN+2.
- inner_start while busy is ignored, with no restart and no effect on the accumulator.
- inner_start in the same cycle as done (DONE state) is ignored. A start is accepted only once the block is back in IDLE.
- Back-to-back: inner_start in the first IDLE cycle after DONE starts a new computation normally.
- a_data and b_data are don't-care whenever the data-valid flag is 0.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3) and default width constants, reused by general_controller-level integration.
- Sub-module: mac_unit, a registered signed multiply-accumulate.
  - Inputs: clk, rst, clear, en, a, b.
  - Output: acc.
- The top level holds the FSM, the address counter and the result register.

Test Plan:
- Single run, unsigned-positive data: LEN=16, A[k]=k, B[k]=1, one-cycle inner_start -> done exactly 18 cycles after the start edge, result=120, busy high for 18 cycles.
- Signed data: A[k]=-3, B[k]=5 for all k -> result=-240 (0xFFF10 at ACC_W=20), done once.
- Extreme products: A[k]=-128, B[k]=-128 for all k -> result=262144 with no overflow at ACC_W=20.
- Start while busy: second inner_start at cycle 5 and again in the DONE cycle -> ignored; single done, result unchanged; a start one cycle later begins a new run.
- Reset mid-run: assert rst at cycle 8 -> all outputs 0 immediately; no done pulse; a subsequent start computes correctly from a clean accumulator.
- Integration with general_controller: drive start high 3 cycles, then low -> a single inner_start pulse; done returns the controller to WAIT; result held stable until the next start.
